// File: rtl/mont_host_sequencer.sv
// -----------------------------------------------------------------------------
// mont_host_sequencer
//
// Hardware host for the Montgomery wrapper command protocol. It accepts one
// job (operands A, B and modulus M) and issues the fixed command sequence
// READ_A, READ_B, READ_M, COMPUTE, WRITE. It moves each operand over the wide
// BRAM data bus and captures the result word that the wrapper returns.
//
// Optional feature macro: MONT_HOST_TIMEOUT_EN
//   When it is defined, a watchdog limits every CMD/ACK wait to TIMEOUT_CYCLES
//   and aborts the job with job_done + job_error. When it is undefined, waits
//   are unbounded and job_error is tied low.
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   job_start            one-cycle job request, honoured only in IDLE
//   job_a/b/m            operands, latched when job_start is accepted
//   job_busy             high from the cycle after acceptance until job_done
//   job_done/job_error   end-of-job pulse / timeout-abort pulse
//   job_result           last captured result word
//   port1_din/valid/read command channel to the wrapper
//   bram_din/_valid      operand channel to the wrapper
//   port2_valid/read     command completion handshake
//   bram_dout/_valid/_read  result channel from the wrapper
//
// Step | command | data
//   0  | 0x0     | A
//   1  | 0x3     | B
//   2  | 0x4     | M
//   3  | 0x1     | none (COMPUTE)
//   4  | 0x2     | none (WRITE)
// -----------------------------------------------------------------------------
module mont_host_sequencer #(
    parameter int RSA_BITS       = 1024,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                job_start,
    input  logic [RSA_BITS-1:0] job_a,
    input  logic [RSA_BITS-1:0] job_b,
    input  logic [RSA_BITS-1:0] job_m,
    output logic                job_busy,
    output logic                job_done,
    output logic                job_error,
    output logic [RSA_BITS-1:0] job_result,
    output logic [31:0]         port1_din,
    output logic                port1_valid,
    input  logic                port1_read,
    output logic [RSA_BITS-1:0] bram_din,
    output logic                bram_din_valid,
    input  logic                port2_valid,
    output logic                port2_read,
    input  logic [RSA_BITS-1:0] bram_dout,
    input  logic                bram_dout_valid,
    output logic                bram_dout_read
);

    // state | meaning
    // IDLE  | waiting for job_start
    // CMD   | command word presented, waiting for port1_read
    // DATA  | single-cycle operand strobe
    // ACK   | waiting for port2_valid
    // HOLD  | port2_read held for two cycles
    // DONE  | job_done pulse, back to IDLE
    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_ACK,
        S_HOLD,
        S_DONE
    } state_t;

    state_t              state;
    logic [2:0]          step;
    logic                hold_cnt;
    logic                captured;
    logic [RSA_BITS-1:0] a_q;
    logic [RSA_BITS-1:0] b_q;
    logic [RSA_BITS-1:0] m_q;
    logic [RSA_BITS-1:0] step_operand;

    function automatic logic [31:0] step_cmd(input logic [2:0] s);
        case (s)
            3'd0:    step_cmd = 32'h0;
            3'd1:    step_cmd = 32'h3;
            3'd2:    step_cmd = 32'h4;
            3'd3:    step_cmd = 32'h1;
            default: step_cmd = 32'h2;
        endcase
    endfunction

    always_comb begin
        step_operand = m_q;
        case (step)
            3'd0:    step_operand = a_q;
            3'd1:    step_operand = b_q;
            default: step_operand = m_q;
        endcase
    end

`ifdef MONT_HOST_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    logic [WAIT_W-1:0] wait_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign job_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= S_IDLE;
            step           <= 3'd0;
            hold_cnt       <= 1'b0;
            captured       <= 1'b0;
            a_q            <= '0;
            b_q            <= '0;
            m_q            <= '0;
            job_busy       <= 1'b0;
            job_done       <= 1'b0;
            job_result     <= '0;
            port1_din      <= '0;
            port1_valid    <= 1'b0;
            bram_din       <= '0;
            bram_din_valid <= 1'b0;
            port2_read     <= 1'b0;
            bram_dout_read <= 1'b0;
`ifdef MONT_HOST_TIMEOUT_EN
            job_error      <= 1'b0;
            wait_cnt       <= '0;
`endif
        end else begin
            job_done <= 1'b0;
`ifdef MONT_HOST_TIMEOUT_EN
            job_error <= 1'b0;
            // Only the staying branches of CMD/ACK increment, so any state
            // change leaves the counter cleared.
            wait_cnt  <= '0;
`endif
            // Result capture runs alongside the FSM so a result word arriving
            // in the same cycle as the WRITE completion is not lost.
            if (step == 3'd4 && bram_dout_valid && !bram_dout_read && !captured) begin
                job_result     <= bram_dout;
                bram_dout_read <= 1'b1;
                captured       <= 1'b1;
            end else begin
                bram_dout_read <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (job_start) begin
                        a_q         <= job_a;
                        b_q         <= job_b;
                        m_q         <= job_m;
                        step        <= 3'd0;
                        captured    <= 1'b0;
                        job_busy    <= 1'b1;
                        port1_din   <= step_cmd(3'd0);
                        port1_valid <= 1'b1;
                        state       <= S_CMD;
                    end
                end

                S_CMD: begin
                    if (port1_read) begin
                        port1_valid <= 1'b0;
                        port1_din   <= '0;
                        if (step < 3'd3) begin
                            bram_din       <= step_operand;
                            bram_din_valid <= 1'b1;
                            state          <= S_DATA;
                        end else begin
                            state <= S_ACK;
                        end
                    end
`ifdef MONT_HOST_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        port1_valid <= 1'b0;
                        port1_din   <= '0;
                        job_busy    <= 1'b0;
                        job_done    <= 1'b1;
                        job_error   <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                S_DATA: begin
                    bram_din       <= '0;
                    bram_din_valid <= 1'b0;
                    state          <= S_ACK;
                end

                S_ACK: begin
                    if (port2_valid) begin
                        port2_read <= 1'b1;
                        hold_cnt   <= 1'b0;
                        state      <= S_HOLD;
                    end
`ifdef MONT_HOST_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        port2_read <= 1'b0;
                        job_busy   <= 1'b0;
                        job_done   <= 1'b1;
                        job_error  <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                S_HOLD: begin
                    if (!hold_cnt) begin
                        hold_cnt <= 1'b1;
                    end else begin
                        port2_read <= 1'b0;
                        if (step == 3'd4) begin
                            job_busy <= 1'b0;
                            job_done <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            step        <= step + 3'd1;
                            port1_din   <= step_cmd(step + 3'd1);
                            port1_valid <= 1'b1;
                            state       <= S_CMD;
                        end
                    end
                end

                S_DONE: begin
                    // Returning step to 0 keeps the capture path closed in IDLE.
                    step  <= 3'd0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mont_host_sequencer.md
Name: mont_host_sequencer

Overview:
- Hardware initiator for the Montgomery wrapper's command protocol; replaces the software/bench host.
- Accepts one job (A, B, M operands) and drives the full command sequence: READ_A, READ_B, READ_M, COMPUTE, WRITE.
- Moves operands over the wide BRAM-data bus and captures the result word.
- Sits between the RSA exponentiation control and montgomery_wrapper; connects to the wrapper's port1, port2 and bram_* pins.

Parameters:
- RSA_BITS, 1024, operand and result width.
- TIMEOUT_CYCLES, 65535, watchdog limit per wait phase; used only with MONT_HOST_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- job_start  in  1  one-cycle request; sampled only in IDLE
- job_a  in  RSA_BITS  operand A; latched on accepted job_start
- job_b  in  RSA_BITS  operand B; latched on accepted job_start
- job_m  in  RSA_BITS  modulus; latched on accepted job_start
- job_busy  out  1  high from the cycle after acceptance until job_done
- job_done  out  1  one-cycle pulse at job end
- job_error  out  1  one-cycle pulse with job_done on timeout abort
- job_result  out  RSA_BITS  captured result; holds until the next capture
- port1_din  out  32  command word to the wrapper
- port1_valid  out  1  command valid
- port1_read  in  1  wrapper accepted the command
- bram_din  out  RSA_BITS  operand to the wrapper
- bram_din_valid  out  1  operand strobe
- port2_valid  in  1  wrapper command complete
- port2_read  out  1  completion acknowledge
- bram_dout  in  RSA_BITS  result from the wrapper
- bram_dout_valid  in  1  result valid
- bram_dout_read  out  1  result acknowledge

Behaviour:
- Reset (resetn=0 at a clk edge): state=IDLE, step=0; all outputs 0, including job_result.
  - A reset mid-job aborts immediately with no job_done.
- Step table: step 0 = cmd 0x0 with A; step 1 = cmd 0x3 with B; step 2 = cmd 0x4 with M; step 3 = cmd 0x1 (COMPUTE, no data); step 4 = cmd 0x2 (WRITE, no data).
- IDLE:
  - job_start=1 latches the operands, sets step=0 and moves to CMD; job_busy rises the next cycle.
  - job_start while busy is ignored.
- CMD:
  - port1_din = step command, port1_valid=1; both held stable until port1_read is sampled 1.
  - Next state: DATA for steps 0-2, ACK for steps 3-4.
  - port1_valid drops in the first DATA/ACK cycle.
- DATA:
  - Exactly one cycle with bram_din = selected operand and bram_din_valid=1, then ACK.
  - bram_din returns to 0 after the strobe.
- ACK:
  - Wait for port2_valid=1.
  - On the first sampled high, assert port2_read for exactly 2 cycles (ACK_HOLD).
  - After ACK_HOLD: step<4 increments step and returns to CMD; step=4 goes to DONE.
- Result capture, any state with step=4:
  - When bram_dout_valid=1 and bram_dout_read=0, job_result <= bram_dout and bram_dout_read=1 for 1 cycle.
  - Only the first capture per job is kept.
  - If port2 completes before any bram_dout_valid, job_result keeps its prior value.
  - bram_dout_read is never asserted outside step 4.
- DONE: job_done=1 for one cycle, job_busy falls the same cycle, then IDLE.
  - A job_start in the DONE cycle is ignored.
- Minimum latency with a zero-wait responder:
  - Per data step: CMD 1 + DATA 1 + ACK 1 + ACK_HOLD 2 = 5 cycles.
  - Per command-only step: 4 cycles.
  - Total: start to done = 23 cycles.
- Simultaneous port2_valid and bram_dout_valid in step 4: both are handled in the same cycle.

Optional Feature:
- MONT_HOST_TIMEOUT_EN defined:
  - A wait counter clears on every state entry and counts cycles spent in CMD or ACK (before port2_valid).
  - Reaching TIMEOUT_CYCLES deasserts port1_valid/port2_read, pulses job_done and job_error together, and returns to IDLE.
  - job_result is unchanged on timeout.
- Undefined: no counter, waits are unbounded, job_error tied to 0.

Test Plan:
- Zero-wait stub responder returning A*B*R^-1 mod M; A=1, B=2, M=3 -> port1_din sequence 0,3,4,1,2; bram_din 1,2,3; job_result=2; job_done exactly 23 cycles after start.
- port1_read delayed 7 cycles on step 1 -> port1_valid=1 and port1_din=0x3 stable for all 8 cycles; no bram_din_valid before acceptance; result still correct.
- A=0x1BA, B=0x91B, M=the 1024-bit test modulus ending ...6F31 -> job_result = value ending ...ADA7; bram_dout_read high exactly one cycle.
- job_start pulsed during step 2 and in the DONE cycle -> ignored; exactly one job_done; latched operands unchanged.
- resetn=0 for one cycle during the COMPUTE ACK wait -> next cycle all outputs 0, state IDLE, no job_done; a fresh job then completes normally.
- With MONT_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=16, port2_valid never asserted on COMPUTE -> job_done and job_error pulse together after the 16th wait cycle; job_result unchanged.
